// File: rtl/uart_rx_pkg.sv
// Shared types for the UART receiver: FSM state encoding, FIFO entry layout and the prescale floor.
// The UART_RX_BREAK_DET_EN build option lives in uart_rx_fifo_core; nothing here depends on it.
package uart_rx_pkg;

  localparam int MIN_PRESCALE = 8;
  localparam int MAX_DWIDTH   = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    STOP2,
    BREAK
  } rx_state_e;

  typedef struct packed {
    logic [MAX_DWIDTH-1:0] data;
    logic                  par_err;
    logic                  frm_err;
  } rx_entry_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO holding received frames. The head entry is read straight from storage,
// and the occupancy count is registered, so "not empty" is a clean flag.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             pop_ok, push_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];

  // A pop in the same cycle frees a slot, so a push into a full FIFO can still land.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo_core.sv
// Oversampling UART receiver with 3-sample majority voting, parity/framing flags and an RX FIFO.
// Define UART_RX_BREAK_DET_EN to add brk_det_rx and hold the FSM in BREAK until the line idles.
module uart_rx_fifo_core
  import uart_rx_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int PWIDTH = 6,
  parameter int FDEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_data_rx,
  input  logic              parity_en_rx,
  input  logic              parity_type_rx,
  input  logic              stop2_rx,
  input  logic [PWIDTH-1:0] prescale_rx,
  output logic [DWIDTH-1:0] p_data_rx,
  output logic              par_err_rx,
  output logic              frm_err_rx,
  output logic              data_valid_rx,
  input  logic              data_ready_rx,
  output logic              overrun_rx,
  input  logic              overrun_clr_rx,
  output logic              busy_rx,
`ifdef UART_RX_BREAK_DET_EN
  output logic              brk_det_rx,
`endif
  output rx_state_e         state_dbg_rx
);

  localparam int BW = $clog2(DWIDTH);

  // Output handshake: a frame leaves the FIFO on a clock where data_valid_rx && data_ready_rx.
  logic              sync1_q, sync2_q, rxs;
  rx_state_e         state_q, state_d;
  logic [PWIDTH-1:0] cnt_q, cnt_d, prescale_q, prescale_d, half, p_in;
  logic [BW-1:0]     bit_idx_q, bit_idx_d;
  logic [DWIDTH-1:0] shift_q, shift_d;
  logic              s0_q, s0_d, s1_q, s1_d;
  logic              par_en_q, par_en_d, par_type_q, par_type_d, stop2_q, stop2_d;
  logic              par_err_q, par_err_d, frm_err_q, frm_err_d;
  logic              busy_q, busy_d, push_q, push_d, overrun_q, overrun_d;
  logic [DWIDTH+1:0] push_word_q, push_word_d;
  logic              tap_lo, tap_mid, tap_hi, bit_end, maj;
  logic              fifo_full, fifo_empty, fifo_pop;
`ifdef UART_RX_BREAK_DET_EN
  logic              par_bit_q, par_bit_d, brk_q, brk_d, is_break;
`endif

  assign rxs     = sync2_q;
  assign p_in    = (prescale_rx < PWIDTH'(MIN_PRESCALE)) ? PWIDTH'(MIN_PRESCALE) : prescale_rx;
  assign half    = prescale_q >> 1;
  assign tap_lo  = (cnt_q == half - PWIDTH'(1));
  assign tap_mid = (cnt_q == half);
  assign tap_hi  = (cnt_q == half + PWIDTH'(1));
  assign bit_end = (cnt_q == prescale_q - PWIDTH'(1));
  assign maj     = majority3(s0_q, s1_q, rxs);
`ifdef UART_RX_BREAK_DET_EN
  assign is_break = (shift_q == '0) && !(par_en_q && par_bit_q) && !maj;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    s0_d        = s0_q;
    s1_d        = s1_q;
    par_en_d    = par_en_q;
    par_type_d  = par_type_q;
    stop2_d     = stop2_q;
    prescale_d  = prescale_q;
    par_err_d   = par_err_q;
    frm_err_d   = frm_err_q;
    push_d      = 1'b0;
    push_word_d = push_word_q;
`ifdef UART_RX_BREAK_DET_EN
    par_bit_d   = par_bit_q;
    brk_d       = 1'b0;
`endif
    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
      if (tap_lo)  s0_d = rxs;
      if (tap_mid) s1_d = rxs;
    end
    case (state_q)
      IDLE: if (!rxs) begin
        state_d    = START;
        cnt_d      = '0;
        prescale_d = p_in;
        par_en_d   = parity_en_rx;
        par_type_d = parity_type_rx;
        stop2_d    = stop2_rx;
        par_err_d  = 1'b0;
        frm_err_d  = 1'b0;
        bit_idx_d  = '0;
`ifdef UART_RX_BREAK_DET_EN
        par_bit_d  = 1'b0;
`endif
      end
      START: begin
        if (tap_hi && maj)  state_d = IDLE;
        else if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (tap_hi) shift_d = {maj, shift_q[DWIDTH-1:1]};
        if (bit_end) begin
          if (bit_idx_q == BW'(DWIDTH - 1)) state_d = par_en_q ? PARITY : STOP;
          else bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      PARITY: begin
        if (tap_hi) begin
          par_err_d = (((^shift_q) ^ maj) != par_type_q);
`ifdef UART_RX_BREAK_DET_EN
          par_bit_d = maj;
`endif
        end
        if (bit_end) state_d = STOP;
      end
      // The final stop decision returns to IDLE mid-bit so a back-to-back start edge is caught.
      STOP: begin
        if (tap_hi) begin
`ifdef UART_RX_BREAK_DET_EN
          if (is_break) begin
            state_d = BREAK;
            brk_d   = 1'b1;
          end else
`endif
          if (stop2_q) frm_err_d = frm_err_q | ~maj;
          else begin
            push_d      = 1'b1;
            push_word_d = {shift_q, par_err_q, frm_err_q | ~maj};
            state_d     = IDLE;
          end
        end else if (bit_end && stop2_q) begin
          state_d = STOP2;
        end
      end
      STOP2: if (tap_hi) begin
        push_d      = 1'b1;
        push_word_d = {shift_q, par_err_q, frm_err_q | ~maj};
        state_d     = IDLE;
      end
      BREAK:   if (rxs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      s0_q        <= 1'b1;
      s1_q        <= 1'b1;
      par_en_q    <= 1'b0;
      par_type_q  <= 1'b0;
      stop2_q     <= 1'b0;
      prescale_q  <= PWIDTH'(MIN_PRESCALE);
      par_err_q   <= 1'b0;
      frm_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      push_q      <= 1'b0;
      push_word_q <= '0;
`ifdef UART_RX_BREAK_DET_EN
      par_bit_q   <= 1'b0;
      brk_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      par_en_q    <= par_en_d;
      par_type_q  <= par_type_d;
      stop2_q     <= stop2_d;
      prescale_q  <= prescale_d;
      par_err_q   <= par_err_d;
      frm_err_q   <= frm_err_d;
      busy_q      <= busy_d;
      push_q      <= push_d;
      push_word_q <= push_word_d;
`ifdef UART_RX_BREAK_DET_EN
      par_bit_q   <= par_bit_d;
      brk_q       <= brk_d;
`endif
    end
  end

  assign fifo_pop  = data_valid_rx && data_ready_rx;
  assign overrun_d = (overrun_q && !overrun_clr_rx) || (push_q && fifo_full && !fifo_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      sync1_q   <= s_data_rx;
      sync2_q   <= sync1_q;
      overrun_q <= overrun_d;
    end
  end

  uart_rx_fifo #(
    .WIDTH (DWIDTH + 2),
    .DEPTH (FDEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_q),
    .wr_data (push_word_q),
    .pop     (fifo_pop),
    .rd_data ({p_data_rx, par_err_rx, frm_err_rx}),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign data_valid_rx = !fifo_empty;
  assign overrun_rx    = overrun_q;
  assign busy_rx       = busy_q;
  assign state_dbg_rx  = state_q;
`ifdef UART_RX_BREAK_DET_EN
  assign brk_det_rx    = brk_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo_core.sv
// Directed bench for uart_rx_fifo_core: serial frames are driven bit by bit, expected FIFO
// entries are queued as frames are sent and compared as they are popped.
module tb_uart_rx_fifo_core;
  import uart_rx_pkg::*;

  localparam int DW = 8;
  localparam int PW = 6;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_data_rx;
  logic          parity_en_rx;
  logic          parity_type_rx;
  logic          stop2_rx;
  logic [PW-1:0] prescale_rx;
  logic [DW-1:0] p_data_rx;
  logic          par_err_rx;
  logic          frm_err_rx;
  logic          data_valid_rx;
  logic          data_ready_rx;
  logic          overrun_rx;
  logic          overrun_clr_rx;
  logic          busy_rx;
  rx_state_e     state_dbg_rx;

  int checks = 0;
  int errors = 0;
  logic [DW+1:0] exp_q[$];

  uart_rx_fifo_core #(
    .DWIDTH (DW),
    .PWIDTH (PW),
    .FDEPTH (FD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_data_rx      (s_data_rx),
    .parity_en_rx   (parity_en_rx),
    .parity_type_rx (parity_type_rx),
    .stop2_rx       (stop2_rx),
    .prescale_rx    (prescale_rx),
    .p_data_rx      (p_data_rx),
    .par_err_rx     (par_err_rx),
    .frm_err_rx     (frm_err_rx),
    .data_valid_rx  (data_valid_rx),
    .data_ready_rx  (data_ready_rx),
    .overrun_rx     (overrun_rx),
    .overrun_clr_rx (overrun_clr_rx),
    .busy_rx        (busy_rx),
    .state_dbg_rx   (state_dbg_rx)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v, input int p, input logic glitch);
    for (int c = 0; c < p; c++) begin
      s_data_rx = (glitch && c == p / 2) ? ~v : v;
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input int p, input logic pen,
                            input logic ptype, input logic pbit, input logic s1,
                            input logic s2en, input logic s2, input int gbit);
    parity_en_rx   = pen;
    parity_type_rx = ptype;
    stop2_rx       = s2en;
    prescale_rx    = p[PW-1:0];
    drive_bit(1'b0, p, 1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i], p, gbit == i);
    if (pen)  drive_bit(pbit, p, 1'b0);
    drive_bit(s1, p, 1'b0);
    if (s2en) drive_bit(s2, p, 1'b0);
    s_data_rx = 1'b1;
  endtask

  task automatic pop_check(input string tag);
    int n = 0;
    logic [DW+1:0] exp;
    while (!data_valid_rx && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(data_valid_rx), 32'd1);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb observed empty queue required an entry", tag);
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_entry"}, 32'({p_data_rx, par_err_rx, frm_err_rx}), 32'(exp));
    end
    data_ready_rx = 1'b1;
    @(negedge clk);
    data_ready_rx = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    s_data_rx      = 1'b1;
    parity_en_rx   = 1'b0;
    parity_type_rx = 1'b0;
    stop2_rx       = 1'b0;
    prescale_rx    = PW'(8);
    data_ready_rx  = 1'b0;
    overrun_clr_rx = 1'b0;
    cycles(3);
    check("rst_valid",   32'(data_valid_rx), 32'd0);
    check("rst_data",    32'(p_data_rx),     32'd0);
    check("rst_flags",   32'({par_err_rx, frm_err_rx}), 32'd0);
    check("rst_overrun", 32'(overrun_rx),    32'd0);
    check("rst_busy",    32'(busy_rx),       32'd0);
    check("rst_state",   32'(state_dbg_rx),  32'(IDLE));
    rst = 1'b0;
    cycles(4);

    // Clean frame, even parity, then pop empties the FIFO
    exp_q.push_back({8'hA5, 1'b0, 1'b0});
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
    pop_check("clean_a5");
    check("pop_clears_valid", 32'(data_valid_rx), 32'd0);

    // Parity bit forced 1 with even type gives an error; with odd type it is correct
    exp_q.push_back({8'hA5, 1'b1, 1'b0});
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, -1);
    pop_check("par_even_bad");
    exp_q.push_back({8'hA5, 1'b0, 1'b0});
    send_frame(8'hA5, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, -1);
    pop_check("par_odd_ok");

    // Low stop bit flags a framing error and the FSM settles back to IDLE
    exp_q.push_back({8'hA5, 1'b0, 1'b1});
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    pop_check("stop_low");
    cycles(40);
    check("stop_low_idle", 32'(busy_rx), 32'd0);
    check("stop_low_state", 32'(state_dbg_rx), 32'(IDLE));

    // All-zero frame with low stop bit is stored as data 0 with frm_err
    exp_q.push_back({8'h00, 1'b0, 1'b1});
    send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    pop_check("zero_frame");
    cycles(40);

    // False start: 3 low cycles at P=16
    prescale_rx = PW'(16);
    s_data_rx = 1'b0;
    cycles(3);
    s_data_rx = 1'b1;
    cycles(3);
    check("false_start_busy", 32'(busy_rx), 32'd1);
    cycles(30);
    check("false_start_idle",  32'(busy_rx),       32'd0);
    check("false_start_nopush", 32'(data_valid_rx), 32'd0);

    // Five back-to-back frames into a 4-deep FIFO with no draining
    for (int i = 1; i <= 5; i++) begin
      if (i <= FD) exp_q.push_back({8'(i), 1'b0, 1'b0});
      send_frame(8'(i), 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
    end
    cycles(20);
    check("overrun_set",  32'(overrun_rx),    32'd1);
    check("overrun_full", 32'(data_valid_rx), 32'd1);
    for (int i = 1; i <= FD; i++) pop_check("fill");
    check("drained_valid",  32'(data_valid_rx), 32'd0);
    check("overrun_sticky", 32'(overrun_rx),    32'd1);
    overrun_clr_rx = 1'b1;
    @(negedge clk);
    overrun_clr_rx = 1'b0;
    check("overrun_cleared", 32'(overrun_rx), 32'd0);

    // Two stop bits: second low gives frm_err, both high is clean
    exp_q.push_back({8'h5A, 1'b0, 1'b1});
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
    pop_check("stop2_low");
    cycles(40);
    exp_q.push_back({8'hC3, 1'b0, 1'b0});
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, -1);
    pop_check("stop2_ok");

    // One-cycle glitch in the middle of data bits is voted out
    exp_q.push_back({8'h96, 1'b0, 1'b0});
    send_frame(8'h96, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3);
    pop_check("glitch_b3");
    exp_q.push_back({8'h69, 1'b0, 1'b0});
    send_frame(8'h69, 12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6);
    pop_check("glitch_b6");

    // Reset in the middle of a frame with an entry already queued
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
    cycles(4);
    prescale_rx = PW'(8);
    drive_bit(1'b0, 8, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 8, 1'b0);
    s_data_rx = 1'b0;
    cycles(4);
    rst = 1'b1;
    s_data_rx = 1'b1;
    cycles(2);
    check("mid_rst_valid", 32'(data_valid_rx), 32'd0);
    check("mid_rst_data",  32'(p_data_rx),     32'd0);
    check("mid_rst_busy",  32'(busy_rx),       32'd0);
    check("mid_rst_state", 32'(state_dbg_rx),  32'(IDLE));
    rst = 1'b0;
    cycles(10);
    check("post_rst_nopush", 32'(data_valid_rx), 32'd0);
    exp_q.push_back({8'h3C, 1'b0, 1'b0});
    send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
    pop_check("post_rst_3c");
    cycles(10);
    check("final_empty", 32'(data_valid_rx), 32'd0);
    check("sb_drained",  32'(exp_q.size()),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
